fetch_sequencer: RTL

FETCH_SEQUENCER -- requirements
Module: fetch_sequencer

---
 rtl/fetch_sequencer.sv | 144 ++++++++++++++
 1 files changed

// File: rtl/fetch_sequencer.sv
// fetch_sequencer
//   Six-slot ring-counter instruction fetch unit with a small internal
//   program RAM. T1..T3 perform the fetch (address, PC increment, IR load),
//   T4 handles jump and halt requests, and T5/T6 are idle execute slots that
//   external control logic can use. The unit holds while run=0 and freezes
//   in HALT until CLR.
//
// Ports
//   CLK        in   clock, rising edge
//   CLR        in   asynchronous active-high reset (RAM contents are kept)
//   run        in   1 = ring counter advances, 0 = hold
//   prog_we    in   program RAM write strobe (accepted only while run=0)
//   prog_addr  in   program RAM write address
//   prog_data  in   program RAM write data
//   jmp_en     in   load PC from jmp_addr (sampled in T4 only)
//   jmp_addr   in   jump target
//   hlt        in   halt request (sampled in T4 only, wins over jmp_en)
//   pc_out     out  program counter
//   mar_out    out  memory address register
//   ir_out     out  instruction register
//   opcode     out  upper OPC_W bits of IR
//   operand    out  remaining low bits of IR
//   t_state    out  one-hot T1..T6 (bit0 = T1), all zero in HALT
//   bus_out    out  shared bus: PC in T1, RAM[MAR] in T3, else 0
//   halted     out  1 while in HALT
//
// State | meaning
//   T1   | address: MAR <= PC, PC drives the bus
//   T2   | increment: PC <= PC + 1
//   T3   | memory: IR <= RAM[MAR], RAM[MAR] drives the bus
//   T4   | control: hlt -> HALT, else jmp_en -> PC <= jmp_addr
//   T5   | execute slot, no register update
//   T6   | execute slot, no register update
//   HALT | t_state = 0, everything frozen until CLR

module fetch_sequencer #(
  parameter int ADDR_W = 4,
  parameter int DATA_W = 8,
  parameter int OPC_W  = 4
) (
  input  logic                      CLK,
  input  logic                      CLR,
  input  logic                      run,
  input  logic                      prog_we,
  input  logic [ADDR_W-1:0]         prog_addr,
  input  logic [DATA_W-1:0]         prog_data,
  input  logic                      jmp_en,
  input  logic [ADDR_W-1:0]         jmp_addr,
  input  logic                      hlt,
  output logic [ADDR_W-1:0]         pc_out,
  output logic [ADDR_W-1:0]         mar_out,
  output logic [DATA_W-1:0]         ir_out,
  output logic [OPC_W-1:0]          opcode,
  output logic [DATA_W-OPC_W-1:0]   operand,
  output logic [5:0]                t_state,
  output logic [DATA_W-1:0]         bus_out,
  output logic                      halted
);

  localparam logic [5:0] ST_T1   = 6'b000001;
  localparam logic [5:0] ST_T2   = 6'b000010;
  localparam logic [5:0] ST_T3   = 6'b000100;
  localparam logic [5:0] ST_T4   = 6'b001000;
  localparam logic [5:0] ST_T5   = 6'b010000;
  localparam logic [5:0] ST_T6   = 6'b100000;
  localparam logic [5:0] ST_HALT = 6'b000000;

  localparam int DEPTH = 2 ** ADDR_W;

  logic [DATA_W-1:0] mem [DEPTH];
  logic [ADDR_W-1:0] pc;
  logic [ADDR_W-1:0] mar;
  logic [DATA_W-1:0] ir;
  logic [5:0]        state;
  logic              halt_q;
  logic [DATA_W-1:0] mem_rd;

  assign mem_rd = mem[mar];

  // Program RAM has no reset so a CLR never wipes a loaded program.
  // Loading is only legal while the sequencer is stopped.
  always_ff @(posedge CLK) begin
    if (prog_we && !run) begin
      mem[prog_addr] <= prog_data;
    end
  end

  always_ff @(posedge CLK or posedge CLR) begin
    if (CLR) begin
      pc     <= '0;
      mar    <= '0;
      ir     <= '0;
      state  <= ST_T1;
      halt_q <= 1'b0;
    end else if (run && !halt_q) begin
      case (state)
        ST_T1: begin
          mar   <= pc;
          state <= ST_T2;
        end
        ST_T2: begin
          pc    <= pc + ADDR_W'(1);
          state <= ST_T3;
        end
        ST_T3: begin
          ir    <= mem_rd;
          state <= ST_T4;
        end
        ST_T4: begin
          if (hlt) begin
            halt_q <= 1'b1;
            state  <= ST_HALT;
          end else begin
            if (jmp_en) begin
              pc <= jmp_addr;
            end
            state <= ST_T5;
          end
        end
        ST_T5:   state <= ST_T6;
        ST_T6:   state <= ST_T1;
        default: state <= state;
      endcase
    end
  end

  always_comb begin
    bus_out = '0;
    if (state == ST_T1) begin
      bus_out = DATA_W'(pc);
    end else if (state == ST_T3) begin
      bus_out = mem_rd;
    end
  end

  assign pc_out  = pc;
  assign mar_out = mar;
  assign ir_out  = ir;
  assign opcode  = ir[DATA_W-1 -: OPC_W];
  assign operand = ir[DATA_W-OPC_W-1:0];
  assign t_state = state;
  assign halted  = halt_q;

endmodule
